// File: rtl/tcdm_port_arb_pkg.sv
// Shared types, widths and helpers for the TCDM port arbiter slice.
package tcdm_port_arb_pkg;

    localparam int PERF_CNT_W = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;

    // Address and SID fields are sized for the widest supported configuration
    // and narrowed to the instance widths at the arbiter ports.
    localparam int ADD_MAX_W  = 64;
    localparam int SID_MAX_W  = 16;

    typedef struct packed {
        logic [ADD_MAX_W-1:0] add;
        logic                 we_n;
        logic [DATA_W-1:0]    wdata;
        logic [BE_W-1:0]      be;
        logic [SID_MAX_W-1:0] sid;
    } tcdm_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_port_arb_fifo.sv
// In-order FIFO of grantee indices, one entry per outstanding TCDM transaction.
module tcdm_port_arb_fifo
    import tcdm_port_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_port_arbiter.sv
// Round-robin arbiter sharing one TCDM initiator port, with in-order response routing.
// Optional performance counters are built when TCDM_PORT_ARB_PERF_CNT_EN is defined.
module tcdm_port_arbiter
    import tcdm_port_arb_pkg::*;
#(
    parameter int NB_REQ          = 2,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int TCDM_ADD_WIDTH  = 32,
    parameter int OUTSTND_DEPTH   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_REQ-1:0]                    req_i,
    input  logic [NB_REQ*TCDM_ADD_WIDTH-1:0]     add_i,
    input  logic [NB_REQ-1:0]                    we_n_i,
    input  logic [NB_REQ*DATA_W-1:0]             wdata_i,
    input  logic [NB_REQ*BE_W-1:0]               be_i,
    input  logic [NB_REQ*TRANS_SID_WIDTH-1:0]    sid_i,
    output logic [NB_REQ-1:0]                    gnt_o,
    output logic [NB_REQ*DATA_W-1:0]             r_rdata_o,
    output logic [NB_REQ-1:0]                    r_valid_o,
    output logic                                 tcdm_req_o,
    output logic [TCDM_ADD_WIDTH-1:0]            tcdm_add_o,
    output logic                                 tcdm_we_n_o,
    output logic [DATA_W-1:0]                    tcdm_wdata_o,
    output logic [BE_W-1:0]                      tcdm_be_o,
    output logic [TRANS_SID_WIDTH-1:0]           tcdm_sid_o,
    input  logic                                 tcdm_gnt_i,
    input  logic [DATA_W-1:0]                    tcdm_r_rdata_i,
    input  logic                                 tcdm_r_valid_i,
    output logic                                 err_o,
    input  logic                                 perf_clr_i,
    output logic [NB_REQ*PERF_CNT_W-1:0]         perf_gnt_cnt_o,
    output logic [PERF_CNT_W-1:0]                perf_stall_cnt_o
);

    localparam int IDX_W = idx_w(NB_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REQ - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] head;
    logic             any_req;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    tcdm_req_t        sel;

    // Search starts at the pointer; the first requester found wins.
    always_comb begin
        int  cand;
        logic found;
        winner = rr_ptr;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NB_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NB_REQ) begin
                cand = cand - NB_REQ;
            end
            if (!found && req_i[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel       = '0;
        sel.add   = ADD_MAX_W'(add_i[winner*TCDM_ADD_WIDTH +: TCDM_ADD_WIDTH]);
        sel.we_n  = we_n_i[winner];
        sel.wdata = wdata_i[winner*DATA_W +: DATA_W];
        sel.be    = be_i[winner*BE_W +: BE_W];
        sel.sid   = SID_MAX_W'(sid_i[winner*TRANS_SID_WIDTH +: TRANS_SID_WIDTH]);
    end

    assign any_req      = |req_i;
    assign tcdm_req_o   = any_req && !fifo_full;
    assign handshake    = tcdm_req_o && tcdm_gnt_i;
    assign tcdm_add_o   = TCDM_ADD_WIDTH'(sel.add);
    assign tcdm_we_n_o  = sel.we_n;
    assign tcdm_wdata_o = sel.wdata;
    assign tcdm_be_o    = sel.be;
    assign tcdm_sid_o   = TRANS_SID_WIDTH'(sel.sid);
    assign r_rdata_o    = {NB_REQ{tcdm_r_rdata_i}};

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        r_valid_o = '0;
        if (tcdm_r_valid_i && !fifo_empty) begin
            r_valid_o[head] = 1'b1;
        end
    end

    tcdm_port_arb_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (OUTSTND_DEPTH)
    ) i_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (handshake),
        .pop   (tcdm_r_valid_i),
        .din   (winner),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response with nothing outstanding is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
            end
            if (tcdm_r_valid_i && fifo_empty && !handshake) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef TCDM_PORT_ARB_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] gnt_cnt [NB_REQ];
    logic [PERF_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            for (int i = 0; i < NB_REQ; i++) begin
                gnt_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NB_REQ; i++) begin
                if (gnt_o[i] && (gnt_cnt[i] != '1)) begin
                    gnt_cnt[i] <= gnt_cnt[i] + PERF_CNT_W'(1);
                end
            end
            if (any_req && !handshake && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NB_REQ; g++) begin : g_perf_out
        assign perf_gnt_cnt_o[g*PERF_CNT_W +: PERF_CNT_W] = gnt_cnt[g];
    end
    assign perf_stall_cnt_o = stall_cnt;
`else
    logic unused_perf_clr;
    assign unused_perf_clr  = perf_clr_i;
    assign perf_gnt_cnt_o   = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// Self-checking bench for tcdm_port_arbiter: directed vector table, corner sequences, random traffic vs. a queue model.
`timescale 1ns/1ps
module tb_tcdm_port_arbiter;

    localparam int NB_REQ = 2;
    localparam int SID_W  = 2;
    localparam int ADD_W  = 32;
    localparam int DEPTH  = 4;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [NB_REQ-1:0]         req_i;
    logic [NB_REQ*ADD_W-1:0]   add_i;
    logic [NB_REQ-1:0]         we_n_i;
    logic [NB_REQ*32-1:0]      wdata_i;
    logic [NB_REQ*4-1:0]       be_i;
    logic [NB_REQ*SID_W-1:0]   sid_i;
    logic [NB_REQ-1:0]         gnt_o;
    logic [NB_REQ*32-1:0]      r_rdata_o;
    logic [NB_REQ-1:0]         r_valid_o;
    logic                      tcdm_req_o;
    logic [ADD_W-1:0]          tcdm_add_o;
    logic                      tcdm_we_n_o;
    logic [31:0]               tcdm_wdata_o;
    logic [3:0]                tcdm_be_o;
    logic [SID_W-1:0]          tcdm_sid_o;
    logic                      tcdm_gnt_i;
    logic [31:0]               tcdm_r_rdata_i;
    logic                      tcdm_r_valid_i;
    logic                      err_o;
    logic                      perf_clr_i;
    logic [NB_REQ*32-1:0]      perf_gnt_cnt_o;
    logic [31:0]               perf_stall_cnt_o;

    always #5 clk_i = ~clk_i;

    tcdm_port_arbiter #(
        .NB_REQ          (NB_REQ),
        .TRANS_SID_WIDTH (SID_W),
        .TCDM_ADD_WIDTH  (ADD_W),
        .OUTSTND_DEPTH   (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .add_i            (add_i),
        .we_n_i           (we_n_i),
        .wdata_i          (wdata_i),
        .be_i             (be_i),
        .sid_i            (sid_i),
        .gnt_o            (gnt_o),
        .r_rdata_o        (r_rdata_o),
        .r_valid_o        (r_valid_o),
        .tcdm_req_o       (tcdm_req_o),
        .tcdm_add_o       (tcdm_add_o),
        .tcdm_we_n_o      (tcdm_we_n_o),
        .tcdm_wdata_o     (tcdm_wdata_o),
        .tcdm_be_o        (tcdm_be_o),
        .tcdm_sid_o       (tcdm_sid_o),
        .tcdm_gnt_i       (tcdm_gnt_i),
        .tcdm_r_rdata_i   (tcdm_r_rdata_i),
        .tcdm_r_valid_i   (tcdm_r_valid_i),
        .err_o            (err_o),
        .perf_clr_i       (perf_clr_i),
        .perf_gnt_cnt_o   (perf_gnt_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pointer as an integer, outstanding grantees as a queue.
    int     m_ptr;
    int     m_q[$];
    bit     m_err;
    longint m_gcnt[NB_REQ];
    longint m_stall;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic [31:0] exp_add;
        logic        exp_we_n;
    } vec_t;

    task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0;
        m_q.delete();
        m_err = 1'b0;
        foreach (m_gcnt[i]) m_gcnt[i] = 0;
        m_stall = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
        req_i          = req;
        tcdm_gnt_i     = gnt;
        tcdm_r_valid_i = rv;
        tcdm_r_rdata_i = rdata;
    endtask

    task automatic setPayload(input int i, input logic [31:0] a, input logic wn, input logic [31:0] d,
                              input logic [3:0] b, input logic [SID_W-1:0] s);
        add_i[i*ADD_W +: ADD_W] = a;
        we_n_i[i]               = wn;
        wdata_i[i*32 +: 32]     = d;
        be_i[i*4 +: 4]          = b;
        sid_i[i*SID_W +: SID_W] = s;
    endtask

    // Compares every output against the model for the current inputs, then advances the model.
    task automatic checkOutput(output bit hs, output int w);
        bit any, treq;
        logic [NB_REQ-1:0] eg, ev;
        any = (req_i != '0);
        w = m_ptr;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            if (req_i[(m_ptr + k) % NB_REQ]) w = (m_ptr + k) % NB_REQ;
        end
        treq = any && (m_q.size() < DEPTH);
        hs   = treq && tcdm_gnt_i;
        eg   = hs ? NB_REQ'(1 << w) : '0;
        ev   = (tcdm_r_valid_i && m_q.size() > 0) ? NB_REQ'(1 << m_q[0]) : '0;
        compareValue("gnt_o", gnt_o, eg);
        compareValue("r_valid_o", r_valid_o, ev);
        compareValue("tcdm_req_o", tcdm_req_o, treq);
        compareValue("err_o", err_o, m_err);
        for (int i = 0; i < NB_REQ; i++) compareValue("r_rdata_o", r_rdata_o[i*32 +: 32], tcdm_r_rdata_i);
        if (any) begin
            compareValue("tcdm_add_o", tcdm_add_o, add_i[w*ADD_W +: ADD_W]);
            compareValue("tcdm_we_n_o", tcdm_we_n_o, we_n_i[w]);
            compareValue("tcdm_wdata_o", tcdm_wdata_o, wdata_i[w*32 +: 32]);
            compareValue("tcdm_be_o", tcdm_be_o, be_i[w*4 +: 4]);
            compareValue("tcdm_sid_o", tcdm_sid_o, sid_i[w*SID_W +: SID_W]);
        end
`ifdef TCDM_PORT_ARB_PERF_CNT_EN
        for (int i = 0; i < NB_REQ; i++) compareValue("perf_gnt_cnt", perf_gnt_cnt_o[i*32 +: 32], m_gcnt[i]);
        compareValue("perf_stall_cnt", perf_stall_cnt_o, m_stall);
`else
        compareValue("perf_gnt_cnt", perf_gnt_cnt_o, 0);
        compareValue("perf_stall_cnt", perf_stall_cnt_o, 0);
`endif
        if (rst_i) begin
            modelReset();
        end else begin
            if (tcdm_r_valid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else if (!hs) m_err = 1'b1;
            end
            if (hs) begin
                m_q.push_back(w);
                m_ptr = (w + 1) % NB_REQ;
            end
            if (perf_clr_i) begin
                foreach (m_gcnt[i]) m_gcnt[i] = 0;
                m_stall = 0;
            end else begin
                if (hs && m_gcnt[w] < CNT_MAX) m_gcnt[w]++;
                if (any && !hs && m_stall < CNT_MAX) m_stall++;
            end
        end
    endtask

    task automatic finishCycle(output bit hs, output int w);
        checkOutput(hs, w);
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle();
        bit hs;
        int w;
        @(negedge clk_i);
        finishCycle(hs, w);
    endtask

    task automatic resetDut();
        rst_i = 1'b1;
        perf_clr_i = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        bit hs;
        int w;
        int grants;
        bit pend[NB_REQ];

        rst_i = 1'b1;
        perf_clr_i = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        setPayload(0, 32'h40, 1'b0, 32'h1111_1111, 4'hF, 2'd1);
        setPayload(1, 32'h100, 1'b1, 32'h2222_2222, 4'h3, 2'd2);
        @(posedge clk_i);
        #1;
        modelReset();
        resetDut();
        compareValue("reset_gnt", gnt_o, 2'b00);
        compareValue("reset_err", err_o, 1'b0);

        // Alternating grants with responses one cycle behind, then a single read from requester 1.
        vecs[0] = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 32'h40,  1'b0};
        vecs[1] = '{2'b11, 1'b1, 1'b1, 32'hA1,        2'b10, 2'b01, 32'h100, 1'b1};
        vecs[2] = '{2'b11, 1'b1, 1'b1, 32'hA2,        2'b01, 2'b10, 32'h40,  1'b0};
        vecs[3] = '{2'b11, 1'b1, 1'b1, 32'hA3,        2'b10, 2'b01, 32'h100, 1'b1};
        vecs[4] = '{2'b00, 1'b0, 1'b1, 32'hA4,        2'b00, 2'b10, 32'h0,   1'b0};
        vecs[5] = '{2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 32'h100, 1'b1};
        vecs[6] = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  2'b00, 2'b10, 32'h0,   1'b0};
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].req, vecs[v].gnt, vecs[v].rv, vecs[v].rdata);
            @(negedge clk_i);
            compareValue($sformatf("vec%0d_gnt", v), gnt_o, vecs[v].exp_gnt);
            compareValue($sformatf("vec%0d_rvalid", v), r_valid_o, vecs[v].exp_rv);
            compareValue($sformatf("vec%0d_rdata1", v), r_rdata_o[63:32], vecs[v].rdata);
            if (vecs[v].req != 2'b00) begin
                compareValue($sformatf("vec%0d_add", v), tcdm_add_o, vecs[v].exp_add);
                compareValue($sformatf("vec%0d_we_n", v), tcdm_we_n_o, vecs[v].exp_we_n);
            end
            finishCycle(hs, w);
        end

        // Full gating: four grants, then a single response frees exactly one slot a cycle later.
        resetDut();
        grants = 0;
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            grants += $countones(gnt_o);
            if (c == 5) compareValue("full_req_low", tcdm_req_o, 1'b0);
            finishCycle(hs, w);
        end
        compareValue("full_grants", grants, 4);
        applyStimulus(2'b11, 1'b1, 1'b1, 32'h55);
        @(negedge clk_i);
        compareValue("full_no_bypass", tcdm_req_o, 1'b0);
        finishCycle(hs, w);
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk_i);
        compareValue("full_release", $countones(gnt_o), 1);
        finishCycle(hs, w);
        @(negedge clk_i);
        compareValue("full_again", tcdm_req_o, 1'b0);
        finishCycle(hs, w);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h77);
        repeat (4) cycle();

        // Stalled winner keeps its payload and the pointer does not move.
        resetDut();
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            compareValue("stall_gnt", gnt_o, 2'b00);
            compareValue("stall_add", tcdm_add_o, 32'h40);
            finishCycle(hs, w);
        end
        tcdm_gnt_i = 1'b1;
        @(negedge clk_i);
        compareValue("stall_then_gnt", gnt_o, 2'b01);
`ifdef TCDM_PORT_ARB_PERF_CNT_EN
        compareValue("stall_cnt3", perf_stall_cnt_o, 3);
`else
        compareValue("stall_cnt_off", perf_stall_cnt_o, 0);
`endif
        finishCycle(hs, w);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        cycle();

        // Response with nothing outstanding: sticky error, cleared only by reset.
        resetDut();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h9);
        @(negedge clk_i);
        compareValue("err_rvalid", r_valid_o, 2'b00);
        finishCycle(hs, w);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        compareValue("err_set", err_o, 1'b1);
        finishCycle(hs, w);
        repeat (3) cycle();
        compareValue("err_sticky", err_o, 1'b1);
        resetDut();
        compareValue("err_cleared", err_o, 1'b0);

        // Reset with two entries outstanding flushes them; late responses are errors.
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle();
        resetDut();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hBB);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            compareValue("flush_rvalid", r_valid_o, 2'b00);
            finishCycle(hs, w);
        end
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk_i);
        compareValue("flush_err", err_o, 1'b1);
        compareValue("flush_ptr0", gnt_o, 2'b01);
        finishCycle(hs, w);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        cycle();

        // Random traffic: requesters hold request and payload until granted.
        resetDut();
        foreach (pend[i]) pend[i] = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NB_REQ; i++) begin
                if (!pend[i] && ($urandom_range(2) == 0)) begin
                    pend[i] = 1'b1;
                    setPayload(i, $urandom, 1'($urandom), $urandom, 4'($urandom), SID_W'($urandom));
                end
                req_i[i] = pend[i];
            end
            tcdm_gnt_i     = ($urandom_range(9) < 7);
            tcdm_r_valid_i = (m_q.size() > 0) && ($urandom_range(1) == 1);
            tcdm_r_rdata_i = $urandom;
            perf_clr_i     = ($urandom_range(49) == 0);
            @(negedge clk_i);
            finishCycle(hs, w);
            if (hs) pend[w] = 1'b0;
        end
        perf_clr_i = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        repeat (DEPTH) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
